pll_lock_sequencer: RTL and testbench
=====================================

# pll_lock_sequencer

Supervises the fabric PLL and sequences the system reset from its lock status. Runs on the always-present board reference clock, never on the PLL output. It:
- clears the PLL steady-lock detector;
- waits for lock with a timeout and bounded retries;
- requires a continuous settle interval before releasing the downstream reset;
- on any lock loss, re-asserts that reset immediately and restarts the sequence.

## Interface
Parameters:
- SYNC_STAGES, 2, flops in each lock-input synchronizer (min 2)
- STDY_RST_CYCLES, 4, cycles `stdy_rst_out` is held high per attempt
- SETTLE_CYCLES, 1024, consecutive cycles both locks must stay high before release
- LOCK_TIMEOUT, 100000, WAIT_LOCK cycles before an attempt fails (10 ms at 10 MHz)
- MAX_RETRIES, 3, failed attempts tolerated before FAULT
- CNT_W, 8, width of lock-loss counter

Ports:
- clock_in  in  1  reference clock (10 MHz board oscillator)
- rst_in  in  1  reset: synchronous and active-low, sampled on rising edge of clock_in
- pll_lock_in  in  1  PLL USR_PLL_LOCKED, asynchronous to clock_in
- pll_lock_stdy_in  in  1  PLL USR_PLL_LOCKED_STDY, asynchronous to clock_in
- retry_in  in  1  single-cycle request to leave FAULT
- stdy_rst_out  out  1  drives PLL USR_LOCKED_STDY_RST
- sys_rst_n_out  out  1  active-low reset for logic clocked by the PLL output
- ready_out  out  1  high only in RUN
- fault_out  out  1  high only in FAULT
- state_out  out  3  current state encoding
- loss_count_out  out  CNT_W  lock losses seen in RUN, saturating

## Operation
- Both lock inputs pass through SYNC_STAGES-flop synchronizers. `lock_ok` = synced lock AND synced lock_stdy.
- State encodings: RESET=0, CLEAR=1, WAIT_LOCK=2, SETTLE=3, RUN=4, LOST=5, FAULT=6. Encodings 7 and above are illegal and go to RESET.
- RESET: entered while rst_in=0. Next state is CLEAR on the first edge with rst_in=1.
- CLEAR: stdy_rst_out=1 for exactly STDY_RST_CYCLES cycles, then WAIT_LOCK. The timeout counter is zeroed on entry.
- WAIT_LOCK: if `lock_ok`, go to SETTLE. Otherwise, when the timeout counter reaches LOCK_TIMEOUT-1:
  - increment the retry count;
  - if the retry count equals MAX_RETRIES, go to FAULT;
  - else go to CLEAR.
- SETTLE: the settle counter increments while `lock_ok`.
  - `lock_ok` low for one cycle: go to WAIT_LOCK; both counters zeroed.
  - Settle counter reaches SETTLE_CYCLES-1 with `lock_ok` high: go to RUN, and the retry count is cleared.
- RUN: sys_rst_n_out=1 and ready_out=1. If `lock_ok` falls, go to LOST.
- LOST: one cycle. loss_count_out increments and saturates at 2^CNT_W-1. Then go to CLEAR.
- FAULT: sys_rst_n_out=0, fault_out=1. Only retry_in=1 exits, to CLEAR with the retry count zeroed. retry_in is ignored in all other states.
- rst_in=0 in any state: on that edge, go to RESET and zero all counters including loss_count_out. This includes mid-SETTLE and RUN.
- Outputs are all registered and decoded from the next state, so they change on the same edge as the state.
- Reset values: stdy_rst_out=1, sys_rst_n_out=0, ready_out=0, fault_out=0, state_out=0, loss_count_out=0.

## Timing
- Input-to-state latency is SYNC_STAGES cycles plus 1 registered decision cycle.
- Lock loss in RUN: sys_rst_n_out goes low SYNC_STAGES+1 edges after pll_lock_in falls.
- Minimum time from rst_in release to sys_rst_n_out=1:
  - 1 cycle (RESET to CLEAR);
  - STDY_RST_CYCLES in CLEAR;
  - at least 1 cycle in WAIT_LOCK;
  - SETTLE_CYCLES in SETTLE.
- Simultaneous `lock_ok` and timeout in WAIT_LOCK: lock wins, go to SETTLE.
- A glitch on `lock_ok` of one synchronized cycle in SETTLE restarts the attempt. It does not count as a retry.
- Counters are sized $clog2 of their limit. All comparisons are equality against the limit minus 1, so no counter overflows.

## Structure
- Shared package `gatemate_clk_pkg` holds:
  - the state encoding constants and the 3-bit state width;
  - reference clock frequency constants, for deriving LOCK_TIMEOUT.
- Sub-module `sync_ff` (parameter STAGES, 1-bit): generic synchronizer, instantiated twice, reusable across clock blocks.
- The FSM, counters and output registers live in pll_lock_sequencer itself.

## Test plan
Bench parameters: STDY_RST_CYCLES=4, SETTLE_CYCLES=16, LOCK_TIMEOUT=64, MAX_RETRIES=2, SYNC_STAGES=2, CNT_W=4.
- Clean start: rst_in low for 5 cycles, then high; both locks held high → stdy_rst_out=1 for 4 cycles; sys_rst_n_out rises exactly 1+4+1+16 cycles after release; ready_out=1.
- Timeout/fault: locks held low → two 64-cycle WAIT_LOCK attempts, each preceded by a 4-cycle stdy_rst pulse; then state_out=6, fault_out=1. A retry_in pulse → CLEAR on the next edge.
- Settle glitch: drop pll_lock_in for 1 cycle at settle count 10 → back to WAIT_LOCK; release delayed by a full 16 more cycles; retry count unchanged.
- Loss in RUN: pll_lock_stdy_in falls → sys_rst_n_out=0 three edges later; loss_count_out=1; stdy_rst_out pulses again. Repeat 20 losses → loss_count_out saturates at 15.
- Reset mid-operation: rst_in low during RUN and during SETTLE → next edge state_out=0, stdy_rst_out=1, sys_rst_n_out=0, loss_count_out=0.

Source files
------------

// File: rtl/gatemate_clk_pkg.sv
// Shared clocking definitions: sequencer state encoding, reference clock
// constants and a counter sizing helper.
package gatemate_clk_pkg;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam logic [STATE_W-1:0] ST_RESET     = 3'd0;
  localparam logic [STATE_W-1:0] ST_CLEAR     = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 3'd2;
  localparam logic [STATE_W-1:0] ST_SETTLE    = 3'd3;
  localparam logic [STATE_W-1:0] ST_RUN       = 3'd4;
  localparam logic [STATE_W-1:0] ST_LOST      = 3'd5;
  localparam logic [STATE_W-1:0] ST_FAULT     = 3'd6;

  // Board oscillator; the lock timeout is derived as a number of reference cycles.
  localparam int REF_CLK_HZ       = 10_000_000;
  localparam int LOCK_TIMEOUT_MS  = 10;
  localparam int LOCK_TIMEOUT_REF = (REF_CLK_HZ / 1000) * LOCK_TIMEOUT_MS;

  // Width of a counter that runs 0 .. limit-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Generic single-bit multi-flop synchronizer for signals entering a clock domain.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL lock supervisor on the reference clock: pulses the steady-lock detector
// reset, waits for lock with timeout/retries, settles, then releases sys reset.
module pll_lock_sequencer
  import gatemate_clk_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int STDY_RST_CYCLES = 4,
  parameter int SETTLE_CYCLES   = 1024,
  parameter int LOCK_TIMEOUT    = LOCK_TIMEOUT_REF,
  parameter int MAX_RETRIES     = 3,
  parameter int CNT_W           = 8
) (
  input  logic             clock_in,
  input  logic             rst_in,
  input  logic             pll_lock_in,
  input  logic             pll_lock_stdy_in,
  input  logic             retry_in,
  output logic             stdy_rst_out,
  output logic             sys_rst_n_out,
  output logic             ready_out,
  output logic             fault_out,
  output logic [2:0]       state_out,
  output logic [CNT_W-1:0] loss_count_out
);

  localparam int CLR_W = cnt_width(STDY_RST_CYCLES);
  localparam int TO_W  = cnt_width(LOCK_TIMEOUT);
  localparam int SET_W = cnt_width(SETTLE_CYCLES);
  localparam int RTY_W = cnt_width(MAX_RETRIES + 1);

  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(STDY_RST_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRIES - 1);

  logic lock_sync;
  logic stdy_sync;
  logic lock_ok;

  state_t     state;
  state_t     next_state;
  logic [CLR_W-1:0] clr_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [SET_W-1:0] settle_cnt;
  logic [RTY_W-1:0] retry_cnt;
  logic [CNT_W-1:0] loss_cnt;
  logic             to_fail;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk   (clock_in),
    .rst_n (rst_in),
    .d     (pll_lock_in),
    .q     (lock_sync)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_stdy (
    .clk   (clock_in),
    .rst_n (rst_in),
    .d     (pll_lock_stdy_in),
    .q     (stdy_sync)
  );

  assign lock_ok = lock_sync & stdy_sync;
  assign to_fail = (state == ST_WAIT_LOCK) && !lock_ok && (to_cnt == TO_LAST);

  // retry_in is a level sampled every edge; a single-cycle high is one request,
  // honoured only while in FAULT and silently dropped in every other state.
  always_comb begin
    next_state = state;
    case (state)
      ST_RESET:     next_state = ST_CLEAR;
      ST_CLEAR:     if (clr_cnt == CLR_LAST) next_state = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_ok)      next_state = ST_SETTLE;
        else if (to_fail) next_state = (retry_cnt == RTY_LAST) ? ST_FAULT : ST_CLEAR;
      end
      ST_SETTLE: begin
        if (!lock_ok)                    next_state = ST_WAIT_LOCK;
        else if (settle_cnt == SET_LAST) next_state = ST_RUN;
      end
      ST_RUN:       if (!lock_ok) next_state = ST_LOST;
      ST_LOST:      next_state = ST_CLEAR;
      ST_FAULT:     if (retry_in) next_state = ST_CLEAR;
      default:      next_state = ST_RESET;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (!rst_in) begin
      state         <= ST_RESET;
      clr_cnt       <= '0;
      to_cnt        <= '0;
      settle_cnt    <= '0;
      retry_cnt     <= '0;
      loss_cnt      <= '0;
      stdy_rst_out  <= 1'b1;
      sys_rst_n_out <= 1'b0;
      ready_out     <= 1'b0;
      fault_out     <= 1'b0;
    end else begin
      state <= next_state;
      // Phase counters run only while the state persists, so every entry starts at zero.
      clr_cnt    <= (state == ST_CLEAR && next_state == ST_CLEAR) ? clr_cnt + CLR_W'(1) : '0;
      to_cnt     <= (state == ST_WAIT_LOCK && next_state == ST_WAIT_LOCK) ?
                    to_cnt + TO_W'(1) : '0;
      settle_cnt <= (state == ST_SETTLE && next_state == ST_SETTLE) ?
                    settle_cnt + SET_W'(1) : '0;

      if (to_fail)
        retry_cnt <= retry_cnt + RTY_W'(1);
      else if ((state == ST_SETTLE && next_state == ST_RUN) ||
               (state == ST_FAULT && next_state == ST_CLEAR))
        retry_cnt <= '0;

      if (state == ST_RUN && next_state == ST_LOST && loss_cnt != '1)
        loss_cnt <= loss_cnt + CNT_W'(1);

      stdy_rst_out  <= (next_state == ST_CLEAR) || (next_state == ST_RESET);
      sys_rst_n_out <= (next_state == ST_RUN);
      ready_out     <= (next_state == ST_RUN);
      fault_out     <= (next_state == ST_FAULT);
    end
  end

  assign state_out      = state;
  assign loss_count_out = loss_cnt;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed-random bench for pll_lock_sequencer: event times are predicted from
// the sequencing rules with plain arithmetic and checked cycle by cycle.
module tb_pll_lock_sequencer;

  localparam int SYNC     = 2;
  localparam int STDY     = 4;
  localparam int SETTLE   = 16;
  localparam int TO       = 64;
  localparam int RETRIES  = 2;
  localparam int CW       = 4;
  localparam int LOSS_MAX = (1 << CW) - 1;
  localparam int REL      = 1 + STDY + 1 + SETTLE;

  localparam int S_RESET = 0, S_CLEAR = 1, S_WAIT = 2, S_SETTLE = 3;
  localparam int S_RUN = 4, S_LOST = 5, S_FAULT = 6;

  logic          clk;
  logic          rst_in;
  logic          pll_lock_in;
  logic          pll_lock_stdy_in;
  logic          retry_in;
  logic          stdy_rst_out;
  logic          sys_rst_n_out;
  logic          ready_out;
  logic          fault_out;
  logic [2:0]    state_out;
  logic [CW-1:0] loss_count_out;

  int errors = 0;
  int checks = 0;
  logic [CW-1:0] exp_q[$];

  pll_lock_sequencer #(
    .SYNC_STAGES     (SYNC),
    .STDY_RST_CYCLES (STDY),
    .SETTLE_CYCLES   (SETTLE),
    .LOCK_TIMEOUT    (TO),
    .MAX_RETRIES     (RETRIES),
    .CNT_W           (CW)
  ) dut (
    .clock_in         (clk),
    .rst_in           (rst_in),
    .pll_lock_in      (pll_lock_in),
    .pll_lock_stdy_in (pll_lock_stdy_in),
    .retry_in         (retry_in),
    .stdy_rst_out     (stdy_rst_out),
    .sys_rst_n_out    (sys_rst_n_out),
    .ready_out        (ready_out),
    .fault_out        (fault_out),
    .state_out        (state_out),
    .loss_count_out   (loss_count_out)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  // Driver helpers: inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_release();
    rst_in = 1'b0;
    repeat (2) tick();
    rst_in = 1'b1;
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // State k edges after entering CLEAR with locks permanently absent.
  function automatic int timeout_state(input int k);
    int p;
    if (k < 1) return S_RESET;
    p = k - 1;
    if (p / (STDY + TO) >= RETRIES) return S_FAULT;
    return (p % (STDY + TO) < STDY) ? S_CLEAR : S_WAIT;
  endfunction

  initial begin
    int g, len, which, run_e, w0, r, es, s;
    logic [CW-1:0] exp_loss;

    // Reset state, clean start with both locks present
    rst_in = 1'b0;
    pll_lock_in = 1'b1;
    pll_lock_stdy_in = 1'b1;
    retry_in = 1'b0;
    repeat (5) tick();
    chk("rst_state", state_out, S_RESET);
    chk("rst_stdy", stdy_rst_out, 1);
    chk("rst_sys_rst_n", sys_rst_n_out, 0);
    chk("rst_ready", ready_out, 0);
    chk("rst_fault", fault_out, 0);
    chk("rst_loss", loss_count_out, 0);
    rst_in = 1'b1;
    for (int k = 1; k <= REL; k++) begin
      tick();
      chk("clean_stdy", stdy_rst_out, 32'(k <= STDY));
      chk("clean_sys_rst_n", sys_rst_n_out, 32'(k >= REL));
    end
    chk("clean_ready", ready_out, 1);
    chk("clean_state", state_out, S_RUN);

    // Repeated lock losses in RUN; counter saturates
    for (int i = 1; i <= 20; i++) begin
      repeat ($urandom_range(1, 8)) begin
        tick();
        chk("run_ready", ready_out, 1);
      end
      len = $urandom_range(1, 10);
      which = $urandom_range(0, 1);
      exp_q.push_back(CW'((i < LOSS_MAX) ? i : LOSS_MAX));
      if (which == 0) pll_lock_in = 1'b0;
      else            pll_lock_stdy_in = 1'b0;
      run_e = imax(SYNC + 1 + STDY + 2, len + SYNC + 1) + SETTLE;
      for (int e = 1; e <= run_e; e++) begin
        tick();
        chk("loss_sys_rst_n", sys_rst_n_out, 32'((e < SYNC + 1) || (e >= run_e)));
        if (e == SYNC + 1) begin
          chk("loss_state_lost", state_out, S_LOST);
          exp_loss = exp_q.pop_front();
          chk("loss_count", loss_count_out, exp_loss);
        end
        if (e == SYNC + 2) begin
          chk("loss_state_clear", state_out, S_CLEAR);
          chk("loss_stdy_pulse", stdy_rst_out, 1);
        end
        if (e == len) begin
          pll_lock_in = 1'b1;
          pll_lock_stdy_in = 1'b1;
        end
      end
    end
    chk("loss_saturated", loss_count_out, LOSS_MAX);

    // Reset asserted while in RUN
    repeat ($urandom_range(1, 5)) tick();
    rst_in = 1'b0;
    tick();
    chk("rstrun_state", state_out, S_RESET);
    chk("rstrun_stdy", stdy_rst_out, 1);
    chk("rstrun_sys_rst_n", sys_rst_n_out, 0);
    chk("rstrun_ready", ready_out, 0);
    chk("rstrun_loss", loss_count_out, 0);

    // One-cycle lock glitch during SETTLE restarts the settle interval
    for (int it = 0; it < 2; it++) begin
      g = (it == 0) ? 8 : $urandom_range(0, 13);
      start_release();
      w0 = 6 + g + SYNC + 1;
      for (int k = 1; k <= w0 + 1 + SETTLE; k++) begin
        tick();
        if (k == 6 + g) chk("glitch_pre_settle", state_out, S_SETTLE);
        if (k == w0)     chk("glitch_wait", state_out, S_WAIT);
        if (k == w0 + 1) chk("glitch_resettle", state_out, S_SETTLE);
        chk("glitch_sys_rst_n", sys_rst_n_out, 32'(k >= w0 + 1 + SETTLE));
        if (k == 6 + g) pll_lock_in = 1'b0;
        if (k == 7 + g) pll_lock_in = 1'b1;
      end
    end

    // Reset asserted mid-SETTLE; the following attempt takes the full time
    start_release();
    s = $urandom_range(6, REL - 1);
    repeat (s) tick();
    chk("rstset_in_settle", state_out, S_SETTLE);
    rst_in = 1'b0;
    tick();
    chk("rstset_state", state_out, S_RESET);
    chk("rstset_stdy", stdy_rst_out, 1);
    chk("rstset_sys_rst_n", sys_rst_n_out, 0);
    chk("rstset_loss", loss_count_out, 0);
    tick();
    rst_in = 1'b1;
    for (int k = 1; k <= REL; k++) begin
      tick();
      if (k >= REL - 1) chk("rstset_release", sys_rst_n_out, 32'(k == REL));
    end

    // Glitch then total lock loss: glitch is not a retry, two timeouts reach FAULT
    g = $urandom_range(0, 13);
    start_release();
    w0 = 6 + g + SYNC + 1;
    for (int k = 1; k <= w0 + STDY + 2 * TO + 3; k++) begin
      tick();
      if (k >= 6 + g) begin
        r = k - w0;
        if (k < w0)                es = S_SETTLE;
        else if (r < TO)           es = S_WAIT;
        else if (r < TO + STDY)    es = S_CLEAR;
        else if (r < 2 * TO + STDY) es = S_WAIT;
        else                       es = S_FAULT;
        chk("fault_path_state", state_out, es);
        chk("fault_path_fault", fault_out, 32'(es == S_FAULT));
        if (k >= w0) chk("fault_path_stdy", stdy_rst_out, 32'(es == S_CLEAR));
      end
      if (k == 6 + g) begin
        pll_lock_in = 1'b0;
        pll_lock_stdy_in = 1'b0;
      end
    end
    chk("fault_sys_rst_n", sys_rst_n_out, 0);

    // Retry leaves FAULT; retry count restarts, stray retry pulses elsewhere are ignored
    retry_in = 1'b1;
    tick();
    retry_in = 1'b0;
    chk("retry_state", state_out, S_CLEAR);
    chk("retry_fault", fault_out, 0);
    chk("retry_stdy", stdy_rst_out, 1);
    for (int k = 2; k <= 1 + RETRIES * (STDY + TO) + 5; k++) begin
      tick();
      chk("timeout_state", state_out, timeout_state(k));
      chk("timeout_fault", fault_out, 32'(timeout_state(k) == S_FAULT));
      retry_in = (k < 1 + RETRIES * (STDY + TO)) && ($urandom_range(0, 3) == 0);
    end
    retry_in = 1'b0;

    // Retry with locks restored runs a full clean sequence
    pll_lock_in = 1'b1;
    pll_lock_stdy_in = 1'b1;
    tick();
    retry_in = 1'b1;
    tick();
    retry_in = 1'b0;
    for (int k = 2; k <= REL; k++) begin
      tick();
      if (k >= REL - 1) chk("retry_release", sys_rst_n_out, 32'(k == REL));
    end
    chk("retry_ready", ready_out, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
